// File: rtl/psum_accumulator_pkg.sv
// Shared types, widths and saturation helper for the partial-sum accumulator.
package psum_accumulator_pkg;

    localparam int unsigned IN_WIDTH  = 16;
    localparam int unsigned ACC_WIDTH = 24;
    localparam int unsigned OUT_WIDTH = 16;
    localparam int unsigned CNT_WIDTH = 8;

    typedef logic signed [IN_WIDTH-1:0]  psum_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic signed [OUT_WIDTH-1:0] act_t;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_e;

    // Output range expressed at accumulator width for the clamp compares.
    localparam acc_t ACT_MAX = acc_t'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam acc_t ACT_MIN = acc_t'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    function automatic act_t sat_to_out(input acc_t sum);
        act_t res;
        if (sum > ACT_MAX) begin
            res = act_t'(ACT_MAX);
        end else if (sum < ACT_MIN) begin
            res = act_t'(ACT_MIN);
        end else begin
            res = act_t'(sum);
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Pass-in / result-out handshake bundle between the psum adder, accumulator and BN stage.
interface psum_accumulator_if #(
    parameter int unsigned CHANNEL_NUM = 128
);
    import psum_accumulator_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    psum_t [CHANNEL_NUM-1:0]      data_in;
    logic                         out_valid;
    logic                         out_ready;
    act_t  [CHANNEL_NUM-1:0]      data_out;

    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out
    );

    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out
    );

endinterface

// File: rtl/psum_acc_lane.sv
// One channel: wide accumulator, pass adder and saturating result register.
module psum_acc_lane
    import psum_accumulator_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  first,
    input  logic  acc_load,
    input  logic  out_load,
    input  psum_t data_in,
    output act_t  data_out
);

    acc_t acc_q;
    acc_t base_c;
    acc_t sum_c;

    // First pass ignores stale accumulator contents, so no clear cycle is needed.
    always_comb begin
        base_c = first ? acc_t'(0) : acc_q;
        sum_c  = base_c + acc_t'(data_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            data_out <= '0;
        end else begin
            if (acc_load) begin
                acc_q <= sum_c;
            end
            if (out_load) begin
                data_out <= sat_to_out(sum_c);
            end
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates PASS_NUM partial-sum passes per channel and hands saturated results downstream.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM = 128,
    parameter int unsigned PASS_NUM    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_clr,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    psum_accumulator_if.slave    bus
);

    if (PASS_NUM < 1 || PASS_NUM > 255) begin : g_bad_pass_num
        $error("psum_accumulator: PASS_NUM must be in 1..255");
    end

    if (ACC_WIDTH < IN_WIDTH + $clog2(PASS_NUM)) begin : g_bad_acc_width
        $error("psum_accumulator: ACC_WIDTH too narrow for PASS_NUM passes");
    end

    acc_state_e           state_q;
    acc_state_e           state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic                 acc_load_c;
    logic                 out_load_c;
    logic                 first_c;
    logic                 last_c;

    act_t [CHANNEL_NUM-1:0] lane_out_c;

    assign first_c = (cnt_q == '0);
    assign last_c  = (cnt_q == CNT_WIDTH'(PASS_NUM - 1));

    // Shared pass counter / handshake FSM; acc_clr wins over any beat or pending result.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        acc_load_c  = 1'b0;
        out_load_c  = 1'b0;
        if (acc_clr) begin
            state_d     = ACC;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (bus.in_valid) begin
                        if (last_c) begin
                            out_load_c  = 1'b1;
                            cnt_d       = '0;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                        end else begin
                            acc_load_c = 1'b1;
                            cnt_d      = cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ACC;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar i = 0; i < int'(CHANNEL_NUM); i++) begin : g_lane
        psum_acc_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .first    (first_c),
            .acc_load (acc_load_c),
            .out_load (out_load_c),
            .data_in  (bus.data_in[i]),
            .data_out (lane_out_c[i])
        );
    end

    // in_ready is a pure state decode so upstream never sees a valid->ready loop.
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = lane_out_c;
    assign pass_cnt      = cnt_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator at PASS_NUM = 9, 3 and 1 with four channels each.
module tb_psum_accumulator;
    import psum_accumulator_pkg::*;

    localparam int unsigned CH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 acc_clr;
    logic [CNT_WIDTH-1:0] cnt9;
    logic [CNT_WIDTH-1:0] cnt3;
    logic [CNT_WIDTH-1:0] cnt1;
    int                   n_tests = 0;
    int                   n_fail  = 0;

    always #5 clk = ~clk;

    psum_accumulator_if #(.CHANNEL_NUM(CH)) bus9 ();
    psum_accumulator_if #(.CHANNEL_NUM(CH)) bus3 ();
    psum_accumulator_if #(.CHANNEL_NUM(CH)) bus1 ();

    psum_accumulator #(.CHANNEL_NUM(CH), .PASS_NUM(9)) u_dut9 (
        .clk(clk), .rst(rst), .acc_clr(acc_clr), .pass_cnt(cnt9), .bus(bus9.slave)
    );
    psum_accumulator #(.CHANNEL_NUM(CH), .PASS_NUM(3)) u_dut3 (
        .clk(clk), .rst(rst), .acc_clr(acc_clr), .pass_cnt(cnt3), .bus(bus3.slave)
    );
    psum_accumulator #(.CHANNEL_NUM(CH), .PASS_NUM(1)) u_dut1 (
        .clk(clk), .rst(rst), .acc_clr(acc_clr), .pass_cnt(cnt1), .bus(bus1.slave)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive9(input logic v, input int a, input int b, input int c, input int d);
        bus9.in_valid    = v;
        bus9.data_in[0]  = psum_t'(a);
        bus9.data_in[1]  = psum_t'(b);
        bus9.data_in[2]  = psum_t'(c);
        bus9.data_in[3]  = psum_t'(d);
    endtask

    task automatic drive3(input logic v, input int a, input int b, input int c, input int d);
        bus3.in_valid    = v;
        bus3.data_in[0]  = psum_t'(a);
        bus3.data_in[1]  = psum_t'(b);
        bus3.data_in[2]  = psum_t'(c);
        bus3.data_in[3]  = psum_t'(d);
    endtask

    task automatic drive1(input logic v, input int a, input int b, input int c, input int d);
        bus1.in_valid    = v;
        bus1.data_in[0]  = psum_t'(a);
        bus1.data_in[1]  = psum_t'(b);
        bus1.data_in[2]  = psum_t'(c);
        bus1.data_in[3]  = psum_t'(d);
    endtask

    task automatic check_out9(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, "_ch0"}, bus9.data_out[0], e0);
        check({tag, "_ch1"}, bus9.data_out[1], e1);
        check({tag, "_ch2"}, bus9.data_out[2], e2);
        check({tag, "_ch3"}, bus9.data_out[3], e3);
    endtask

    task automatic check_out3(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, "_ch0"}, bus3.data_out[0], e0);
        check({tag, "_ch1"}, bus3.data_out[1], e1);
        check({tag, "_ch2"}, bus3.data_out[2], e2);
        check({tag, "_ch3"}, bus3.data_out[3], e3);
    endtask

    initial begin
        rst     = 1'b1;
        acc_clr = 1'b0;
        drive9(1'b0, 0, 0, 0, 0);
        drive3(1'b0, 0, 0, 0, 0);
        drive1(1'b0, 0, 0, 0, 0);
        bus9.out_ready = 1'b0;
        bus3.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", bus9.in_ready, 1);
        check("rst_out_valid", bus9.out_valid, 0);
        check("rst_pass_cnt", cnt9, 0);
        check_out9("rst_data", 0, 0, 0, 0);

        // Nominal: 9 x +3 with in_valid held and out_ready high.
        bus9.out_ready = 1'b1;
        drive9(1'b1, 3, 3, 3, 3);
        repeat (8) @(negedge clk);
        check("nom_cnt8", cnt9, 8);
        check("nom_not_yet_valid", bus9.out_valid, 0);
        @(negedge clk);
        check("nom_valid", bus9.out_valid, 1);
        check("nom_in_ready_low", bus9.in_ready, 0);
        check("nom_cnt_wrap", cnt9, 0);
        check_out9("nom_data", 27, 27, 27, 27);
        @(negedge clk);
        check("nom_released", bus9.out_valid, 0);
        check("nom_in_ready_back", bus9.in_ready, 1);
        check("nom_hold_beat_ignored", cnt9, 0);
        drive9(1'b0, 0, 0, 0, 0);

        // Saturation at both rails.
        drive9(1'b1, 32767, -32768, 4000, -4000);
        repeat (9) @(negedge clk);
        drive9(1'b0, 0, 0, 0, 0);
        check("sat_valid", bus9.out_valid, 1);
        check_out9("sat_data", 32767, -32768, 32767, -32768);
        @(negedge clk);
        check("sat_released", bus9.out_valid, 0);

        // acc_clr after 4 passes drops the concurrent beat and restarts counting.
        drive9(1'b1, 5, 5, 5, 5);
        repeat (4) @(negedge clk);
        check("clr_cnt4", cnt9, 4);
        acc_clr = 1'b1;
        drive9(1'b1, 100, 100, 100, 100);
        @(negedge clk);
        acc_clr = 1'b0;
        check("clr_cnt0", cnt9, 0);
        check("clr_in_ready", bus9.in_ready, 1);
        check("clr_out_valid", bus9.out_valid, 0);
        drive9(1'b1, 1, 1, 1, 1);
        repeat (9) @(negedge clk);
        drive9(1'b0, 0, 0, 0, 0);
        check("clr_valid", bus9.out_valid, 1);
        check_out9("clr_data", 9, 9, 9, 9);
        @(negedge clk);

        // Reset while holding a result.
        bus9.out_ready = 1'b0;
        drive9(1'b1, 2, 2, 2, 2);
        repeat (9) @(negedge clk);
        drive9(1'b0, 0, 0, 0, 0);
        check("rh_valid", bus9.out_valid, 1);
        check_out9("rh_data", 18, 18, 18, 18);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rh_out_valid", bus9.out_valid, 0);
        check("rh_in_ready", bus9.in_ready, 1);
        check("rh_cnt", cnt9, 0);
        check_out9("rh_cleared", 0, 0, 0, 0);

        // Reset after pass 5, then a clean run.
        drive9(1'b1, 7, 7, 7, 7);
        repeat (5) @(negedge clk);
        check("rp_cnt5", cnt9, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rp_cnt0", cnt9, 0);
        check("rp_out_valid", bus9.out_valid, 0);
        check("rp_in_ready", bus9.in_ready, 1);
        drive9(1'b1, 1, -1, 2, 0);
        repeat (9) @(negedge clk);
        drive9(1'b0, 0, 0, 0, 0);
        check("rp_valid", bus9.out_valid, 1);
        check_out9("rp_data", 9, -9, 18, 0);
        bus9.out_ready = 1'b1;
        @(negedge clk);

        // Signed mix at PASS_NUM=3 followed by backpressure.
        drive3(1'b1, 100, -1, 0, 5);
        @(negedge clk);
        drive3(1'b1, -250, -1, 0, 5);
        @(negedge clk);
        drive3(1'b1, 7, -1, 0, 5);
        @(negedge clk);
        drive3(1'b1, 1000, 1000, 1000, 1000);
        check("mix_valid", bus3.out_valid, 1);
        check_out3("mix_data", -143, -3, 0, 15);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", k), bus3.out_valid, 1);
            check($sformatf("bp%0d_in_ready", k), bus3.in_ready, 0);
            check($sformatf("bp%0d_cnt", k), cnt3, 0);
            check($sformatf("bp%0d_ch0", k), bus3.data_out[0], -143);
        end
        bus3.out_ready = 1'b1;
        drive3(1'b1, 10, 10, 10, 10);
        @(negedge clk);
        check("bp_release_valid", bus3.out_valid, 0);
        check("bp_release_in_ready", bus3.in_ready, 1);
        check("bp_release_cnt", cnt3, 0);
        @(negedge clk);
        check("bp_first_beat_cnt", cnt3, 1);
        repeat (2) @(negedge clk);
        drive3(1'b0, 0, 0, 0, 0);
        check("bp_new_valid", bus3.out_valid, 1);
        check_out3("bp_new_data", 30, 30, 30, 30);
        @(negedge clk);

        // PASS_NUM=1 goes straight to HOLD; acc_clr discards the held result only.
        drive1(1'b1, -5, -32768, 32767, 0);
        @(negedge clk);
        drive1(1'b0, 0, 0, 0, 0);
        check("p1_valid", bus1.out_valid, 1);
        check("p1_cnt", cnt1, 0);
        check("p1_ch0", bus1.data_out[0], -5);
        check("p1_ch1", bus1.data_out[1], -32768);
        check("p1_ch2", bus1.data_out[2], 32767);
        check("p1_ch3", bus1.data_out[3], 0);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        check("p1_clr_valid", bus1.out_valid, 0);
        check("p1_clr_in_ready", bus1.in_ready, 1);
        check("p1_clr_keep_data", bus1.data_out[0], -5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
